// File: rtl/dsp_calc_multibunch.sv
// dsp_calc_multibunch: charge-weighted position product plus per-bunch delayed correction,
// scaled/saturated to the feedback DAC word, with feedback-window and DAC-strobe gates
module dsp_calc_multibunch #(
  parameter int CHARGE_W = 21,
  parameter int SIGNAL_W = 17,
  parameter int OUT_W = 15,
  parameter int FRAC_SHIFT = 12,
  parameter int NBUNCH = 3,
  parameter int CNT_W = 8,
  parameter int CAP_IDX = 4,
  parameter int IDLE_CNT = 10,
  localparam int IDX_W = NBUNCH > 1 ? $clog2(NBUNCH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [CHARGE_W-1:0] charge_in,
  input  logic [SIGNAL_W-1:0] signal_in,
  input  logic store_strb,
  input  logic bunch_strb,
  input  logic delay_en,
  input  logic fb_en,
  input  logic sat_en,
  input  logic [CNT_W-1:0] fb_start,
  input  logic [CNT_W-1:0] dac_start,
  output logic [OUT_W-1:0] pout,
  output logic dsp_oflow,
  output logic [15:0] oflow_cnt,
  output logic [IDX_W-1:0] bunch_idx,
  output logic fb_cond,
  output logic dac_clk
);
  localparam int PW = CHARGE_W + SIGNAL_W;
  localparam int SW = PW + 1;
  localparam int HI = FRAC_SHIFT + OUT_W - 1;
  logic [CHARGE_W-1:0] charge_q;
  logic [PW-1:0] prod;
  logic [SW-1:0] sum, dly_ext;
  logic [OUT_W-1:0] delayed_q, sat_val, pout_nxt;
  logic [OUT_W-1:0] mem [NBUNCH];
  logic [CNT_W-1:0] j;
  logic [CNT_W:0] j_x, fb_x, dac_x;
  logic first, oflow, capture;
  // delayed term is an integer DAC word, so it lines up with the product after the LUT shift
  assign dly_ext = {{(SW-OUT_W){delayed_q[OUT_W-1]}}, delayed_q} << FRAC_SHIFT;
  assign oflow = !((&sum[SW-1:HI]) || !(|sum[SW-1:HI]));
  assign sat_val = {sum[SW-1], {(OUT_W-1){!sum[SW-1]}}};
  assign pout_nxt = oflow && sat_en ? sat_val : sum[HI:FRAC_SHIFT];
  assign capture = delay_en && j == CNT_W'(CAP_IDX);
  // window compares are one bit wider so start+1 never wraps back to count 0
  assign j_x = {1'b0, j};
  assign fb_x = {1'b0, fb_start};
  assign dac_x = {1'b0, dac_start};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      charge_q <= '0;
      prod <= '0;
      sum <= '0;
      pout <= '0;
      dsp_oflow <= 1'b0;
      oflow_cnt <= '0;
      delayed_q <= '0;
    end else begin
      charge_q <= charge_in;
      prod <= PW'($signed(charge_q)) * PW'($signed(signal_in));
      sum <= {prod[PW-1], prod} + dly_ext;
      pout <= pout_nxt;
      dsp_oflow <= oflow;
      delayed_q <= mem[bunch_idx];
      if (oflow && !(&oflow_cnt)) oflow_cnt <= oflow_cnt + 16'd1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      j <= CNT_W'(IDLE_CNT);
      bunch_idx <= '0;
      first <= 1'b1;
    end else if (!store_strb) begin
      j <= CNT_W'(IDLE_CNT);
      bunch_idx <= '0;
      first <= 1'b1;
    end else if (bunch_strb) begin
      j <= '0;
      first <= 1'b0;
      bunch_idx <= first ? '0 : bunch_idx == IDX_W'(NBUNCH-1) ? '0 : bunch_idx + IDX_W'(1);
    end else
      j <= &j ? j : j + CNT_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < NBUNCH; i++) mem[i] <= '0;
    else if (!store_strb)
      for (int i = 0; i < NBUNCH; i++) mem[i] <= '0;
    else if (capture)
      mem[bunch_idx] <= pout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fb_cond <= 1'b0;
      dac_clk <= 1'b0;
    end else begin
      fb_cond <= fb_en && (j_x == fb_x || j_x == fb_x + (CNT_W+1)'(1));
      dac_clk <= fb_en && (j_x == dac_x || j_x == dac_x + (CNT_W+1)'(1));
    end
endmodule

// File: tb/tb_dsp_calc_multibunch.sv
// tb_dsp_calc_multibunch: scoreboard bench for the multibunch feedback calculator
module tb_dsp_calc_multibunch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [20:0] charge_in;
  logic [16:0] signal_in;
  logic store_strb, bunch_strb, delay_en, fb_en, sat_en;
  logic [7:0] fb_start, dac_start;
  logic [14:0] pout;
  logic dsp_oflow;
  logic [15:0] oflow_cnt;
  logic [1:0] bunch_idx;
  logic fb_cond, dac_clk;
  int checks = 0;
  int errors = 0;
  int exp_ocnt = 0;
  logic [15:0] expq[$];
  logic [15:0] e;
  logic push = 1'b0;
  logic [2:0] vld = '0;
  always #5 clk = ~clk;
  dsp_calc_multibunch dut (
    .clk(clk), .rst(rst), .charge_in(charge_in), .signal_in(signal_in),
    .store_strb(store_strb), .bunch_strb(bunch_strb), .delay_en(delay_en),
    .fb_en(fb_en), .sat_en(sat_en), .fb_start(fb_start), .dac_start(dac_start),
    .pout(pout), .dsp_oflow(dsp_oflow), .oflow_cnt(oflow_cnt), .bunch_idx(bunch_idx),
    .fb_cond(fb_cond), .dac_clk(dac_clk)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    push = 1'b0;
  endtask
  task automatic sb_push(input int ep, input bit eo);
    expq.push_back({eo, 15'(ep)});
    push = 1'b1;
  endtask
  // the pushed sample's result reaches pout three edges later
  always @(posedge clk) vld <= {vld[1:0], push};
  always @(negedge clk)
    if (vld[2]) begin
      if (expq.size() == 0)
        chk("sb_empty", 32'(expq.size()), 1);
      else begin
        e = expq.pop_front();
        chk("pout", pout, e[14:0]);
        chk("dsp_oflow", dsp_oflow, e[15]);
      end
    end
  task automatic pulse(input int c, input int s, input int ep, input bit eo);
    charge_in = 21'(c);
    signal_in = '0;
    cyc();
    charge_in = '0;
    signal_in = 17'(s);
    sb_push(ep, eo);
    if (eo) exp_ocnt++;
    cyc();
    signal_in = '0;
    repeat (4) cyc();
    chk("oflow_cnt", oflow_cnt, exp_ocnt);
  endtask
  task automatic bunch(input int s, input int ep, input int eb, input int drop);
    logic prev_en;
    bunch_strb = 1'b1;
    signal_in = 17'(s);
    prev_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        chk("fb_cond", fb_cond, prev_en && (i == 4 || i == 5));
        chk("dac_clk", dac_clk, prev_en && (i == 8 || i == 9));
        if (i == 3) chk("bunch_idx", bunch_idx, eb);
      end
      if (i == drop) fb_en = 1'b0;
      if (i == 2) sb_push(ep, 1'b0);
      prev_en = fb_en;
      cyc();
      bunch_strb = 1'b0;
    end
  endtask
  initial begin
    charge_in = '0;
    signal_in = '0;
    store_strb = 1'b0;
    bunch_strb = 1'b0;
    delay_en = 1'b0;
    fb_en = 1'b0;
    sat_en = 1'b1;
    fb_start = 8'd2;
    dac_start = 8'd6;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pout", pout, 0);
    chk("rst_oflow", dsp_oflow, 0);
    chk("rst_ocnt", oflow_cnt, 0);
    chk("rst_idx", bunch_idx, 0);
    chk("rst_fb", fb_cond, 0);
    chk("rst_dac", dac_clk, 0);
    rst = 1'b0;
    cyc();
    pulse(4096, 100, 100, 0);
    pulse(-4096, 100, -100, 0);
    pulse(2048, 101, 50, 0);
    pulse(2048, -101, -51, 0);
    pulse(4096, -16384, -16384, 0);
    pulse(4096, 16383, 16383, 0);
    pulse(1048575, 65535, 16383, 1);
    sat_en = 1'b0;
    pulse(1048575, 65535, -272, 1);
    pulse(4096, 16384, -16384, 1);
    sat_en = 1'b1;
    pulse(4096, 16384, 16383, 1);
    pulse(4096, -65535, -16384, 1);
    charge_in = 21'd4096;
    delay_en = 1'b1;
    store_strb = 1'b1;
    cyc();
    cyc();
    for (int t = 0; t < 2; t++)
      for (int b = 0; b < 3; b++) begin
        fb_en = t == 1;
        bunch(10 * (b + 1), 10 * (b + 1) * (t + 1), b, t == 0 || b == 0 ? -1 : b == 1 ? 4 : 8);
      end
    fb_en = 1'b0;
    bunch(10, 30, 0, -1);
    bunch(20, 60, 1, -1);
    store_strb = 1'b0;
    bunch_strb = 1'b1;
    fb_en = 1'b1;
    fb_start = 8'd10;
    cyc();
    bunch_strb = 1'b0;
    chk("idx_clr", bunch_idx, 0);
    cyc();
    chk("fb_idle", fb_cond, 1);
    cyc();
    chk("fb_idle", fb_cond, 1);
    fb_en = 1'b0;
    fb_start = 8'd2;
    store_strb = 1'b1;
    cyc();
    cyc();
    for (int b = 0; b < 3; b++) bunch(10 * (b + 1), 10 * (b + 1), b, -1);
    charge_in = 21'd4096;
    signal_in = '0;
    cyc();
    charge_in = '0;
    signal_in = 17'd100;
    cyc();
    signal_in = '0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pout", pout, 0);
    chk("mid_rst_ocnt", oflow_cnt, 0);
    chk("mid_rst_idx", bunch_idx, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_pout", pout, 0);
    end
    chk("sb_drain", 32'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
